// File: rtl/seq_muldiv_unit_if.sv
// Request/result bundle for the iterative multiply/divide engine.
// The core side drives i_* (master); the engine drives o_* (slave).
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [2:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result_lo;
  logic [WIDTH-1:0] o_result_hi;
  logic [1:0]       o_flags;
  logic             o_divz;

  modport master (
    output i_start, i_op, i_a, i_b,
    input  o_busy, o_done, o_result_lo, o_result_hi, o_flags, o_divz
  );

  modport slave (
    input  i_start, i_op, i_a, i_b,
    output o_busy, o_done, o_result_lo, o_result_hi, o_flags, o_divz
  );
endinterface

// File: rtl/seq_muldiv_unit.sv
// Shared iterative engine for MUL/UMULL/SMULL/UDIV/SDIV: one bit per cycle,
// with sign handling done once before (PREP) and once after (FIX) the loop.
module seq_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_UMULL = 3'b001;
  localparam logic [2:0] OP_SMULL = 3'b010;
  localparam logic [2:0] OP_UDIV  = 3'b011;
  localparam logic [2:0] OP_SDIV  = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_neg;
  logic               r_rem_neg;
  logic               r_divz_pend;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_res_lo;
  logic [WIDTH-1:0]   r_res_hi;
  logic [1:0]         r_flags;
  logic               r_divz;

  logic               w_is_div;
  logic               w_is_signed;
  logic               w_is_long;
  logic               w_valid_op;
  logic               w_short_path;
  logic               w_last_iter;
  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_step;
  logic [WIDTH:0]     w_div_trial;
  logic [2*WIDTH-1:0] w_div_step;
  logic [2*WIDTH-1:0] w_prod_neg;
  logic [WIDTH-1:0]   w_res_lo;
  logic [WIDTH-1:0]   w_res_hi;
  logic [1:0]         w_flags;

  assign w_is_div     = (r_op == OP_UDIV) || (r_op == OP_SDIV);
  assign w_is_signed  = (r_op == OP_SMULL) || (r_op == OP_SDIV);
  assign w_is_long    = (r_op == OP_UMULL) || (r_op == OP_SMULL);
  assign w_valid_op   = (r_op <= OP_SDIV);
  assign w_short_path = !w_valid_op || (w_is_div && (r_b == '0));
  assign w_last_iter  = (r_cnt == CW'(WIDTH - 1));

  assign w_sign_a = w_is_signed & r_a[WIDTH-1];
  assign w_sign_b = w_is_signed & r_b[WIDTH-1];
  assign w_mag_a  = w_sign_a ? ({WIDTH{1'b0}} - r_a) : r_a;
  assign w_mag_b  = w_sign_b ? ({WIDTH{1'b0}} - r_b) : r_b;

  // Multiply: acc = {partial, multiplier}; add multiplicand into the top half, shift right.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
  assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
  assign w_div_step  = w_div_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                          : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod_neg = {(2*WIDTH){1'b0}} - r_acc;

  always_comb begin
    w_res_lo = '0;
    w_res_hi = '0;
    case (r_op)
      OP_MUL: begin
        w_res_lo = r_acc[WIDTH-1:0];
      end
      OP_UMULL: begin
        {w_res_hi, w_res_lo} = r_acc;
      end
      OP_SMULL: begin
        {w_res_hi, w_res_lo} = r_neg ? w_prod_neg : r_acc;
      end
      OP_UDIV: begin
        {w_res_hi, w_res_lo} = r_acc;
      end
      OP_SDIV: begin
        w_res_lo = r_neg     ? ({WIDTH{1'b0}} - r_acc[WIDTH-1:0])       : r_acc[WIDTH-1:0];
        w_res_hi = r_rem_neg ? ({WIDTH{1'b0}} - r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
      end
      default: begin
        w_res_lo = '0;
        w_res_hi = '0;
      end
    endcase
    if (w_is_long) begin
      w_flags = {w_res_hi[WIDTH-1], ({w_res_hi, w_res_lo} == '0)};
    end else begin
      w_flags = {w_res_lo[WIDTH-1], (w_res_lo == '0)};
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (bus.i_start) w_state_next = S_PREP;
      S_PREP: w_state_next = w_short_path ? S_FIX : S_ITER;
      S_ITER: if (w_last_iter) w_state_next = S_FIX;
      S_FIX:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_neg       <= 1'b0;
      r_rem_neg   <= 1'b0;
      r_divz_pend <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_res_lo    <= '0;
      r_res_hi    <= '0;
      r_flags     <= '0;
      r_divz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_op   <= bus.i_op;
            r_a    <= bus.i_a;
            r_b    <= bus.i_b;
            r_cnt  <= '0;
            r_busy <= 1'b1;
          end
        end
        S_PREP: begin
          r_neg       <= 1'b0;
          r_rem_neg   <= 1'b0;
          r_divz_pend <= 1'b0;
          if (!w_valid_op) begin
            r_acc <= '0;
          end else if (w_is_div && (r_b == '0)) begin
            // Quotient 0, remainder = raw dividend, no sign fix-up.
            r_acc       <= {r_a, {WIDTH{1'b0}}};
            r_divz_pend <= 1'b1;
          end else begin
            r_a       <= w_mag_a;
            r_b       <= w_mag_b;
            r_neg     <= w_sign_a ^ w_sign_b;
            r_rem_neg <= w_sign_a;
            r_acc     <= w_is_div ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
          end
        end
        S_ITER: begin
          r_acc <= w_is_div ? w_div_step : w_mul_step;
          r_cnt <= w_last_iter ? '0 : r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
        S_FIX: begin
          r_res_lo <= w_res_lo;
          r_res_hi <= w_res_hi;
          r_flags  <= w_flags;
          r_divz   <= r_divz_pend;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_result_lo = r_res_lo;
  assign bus.o_result_hi = r_res_hi;
  assign bus.o_flags     = r_flags;
  assign bus.o_divz      = r_divz;
endmodule
